// File: rtl/mem_fill_drain_ctrl.sv
// -----------------------------------------------------------------------------
// mem_fill_drain_ctrl
//
// Fill-then-drain block buffer. A block of 2**ADDR words is captured from the
// input stream into an internal RAM. The words are then streamed back out in
// address order, either once (LOOP=0, ends in DONE) or forever (LOOP=1).
//
// Handshake semantics, both sides: a word transfers in any cycle where valid
// and ready are both high at the rising edge. A producer holds valid and data
// stable until the transfer happens. Ready may change freely.
//
// Ports
//   i_clk          clock, all logic on posedge
//   i_rst          synchronous active-high reset, highest priority
//   i_in_valid     input word valid
//   i_in_data      input word
//   o_in_ready     input accept, high in FILL
//   o_out_valid    output word valid (skid not empty)
//   o_out_data     output word (skid head)
//   i_out_ready    downstream accept
//   i_restart      single-cycle pulse: abandon current phase and refill
//   o_state        FILL=00, DRAIN=01, DONE=10 (11 behaves as FILL)
//   o_done         high while in DONE
//   o_pass_count   completed drain passes, wraps modulo 2**PASS_W
// -----------------------------------------------------------------------------
module mem_fill_drain_ctrl #(
    parameter int WIDTH  = 32,
    parameter int ADDR   = 10,
    parameter int LOOP   = 1,
    parameter int PASS_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    input  logic [WIDTH-1:0]  i_in_data,
    output logic              o_in_ready,
    output logic              o_out_valid,
    output logic [WIDTH-1:0]  o_out_data,
    input  logic              i_out_ready,
    input  logic              i_restart,
    output logic [1:0]        o_state,
    output logic              o_done,
    output logic [PASS_W-1:0] o_pass_count
);

    localparam int              DEPTH = 2 ** ADDR;
    localparam logic [ADDR-1:0] LAST  = {ADDR{1'b1}};

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Storage; contents are deliberately never reset.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR-1:0]   r_wr_addr;
    logic [ADDR-1:0]   r_rd_addr;
    logic              r_rd_more;
    logic [PASS_W-1:0] r_pass_count;

    // Two-entry skid FIFO. The RAM's registered read lands directly in the
    // entry at the write pointer, so an issued word is visible the next cycle.
    logic [WIDTH-1:0]  r_skid_data [2];
    logic [1:0]        r_skid_last;   // entry holds the word from address DEPTH-1
    logic              r_skid_rp;
    logic              r_skid_wp;
    logic [1:0]        r_skid_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_issue;
    logic              w_pop;
    logic              w_last_pop;
    logic [1:0]        w_occ;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and per-cycle strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = (r_skid_cnt != 2'd0);
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_pop       = 1'b0;
        w_last_pop  = 1'b0;
        w_occ       = r_skid_cnt;

        case (r_state)
            ST_DRAIN: begin
                w_pop      = w_out_valid & i_out_ready;
                // Occupancy after this cycle's pop; a new read may issue
                // whenever that leaves room, which keeps full throughput.
                w_occ      = r_skid_cnt - {1'b0, w_pop};
                w_issue    = r_rd_more && (w_occ < 2'd2);
                w_last_pop = w_pop & r_skid_last[r_skid_rp];
                if (w_last_pop && (LOOP == 0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                // FILL, and the unused encoding, which behaves as FILL.
                w_in_ready  = 1'b1;
                w_accept    = i_in_valid;
                w_state_nxt = ST_FILL;
                if (i_in_valid && (r_wr_addr == LAST)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
        endcase

        // Restart overrides any same-cycle accept, issue or pop.
        if (i_restart) begin
            w_state_nxt = ST_FILL;
            w_accept    = 1'b0;
            w_issue     = 1'b0;
            w_pop       = 1'b0;
            w_last_pop  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_accept) begin
            mem[r_wr_addr] <= i_in_data;
        end
    end

    // -------------------------------------------------------------------------
    // RAM read into skid storage
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_skid_data[0] <= '0;
            r_skid_data[1] <= '0;
        end else if (w_issue) begin
            r_skid_data[r_skid_wp] <= mem[r_rd_addr];
        end
    end

    // -------------------------------------------------------------------------
    // Address, skid bookkeeping and pass counter
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_rd_more    <= 1'b0;
            r_skid_last  <= 2'b00;
            r_skid_rp    <= 1'b0;
            r_skid_wp    <= 1'b0;
            r_skid_cnt   <= 2'd0;
            r_pass_count <= '0;
        end else if (i_restart) begin
            // Flush everything in flight; the pass counter survives.
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_rd_more    <= 1'b0;
            r_skid_last  <= 2'b00;
            r_skid_rp    <= 1'b0;
            r_skid_wp    <= 1'b0;
            r_skid_cnt   <= 2'd0;
        end else begin
            if (w_accept) begin
                // wr_addr wraps to 0 on the last accept of the block.
                r_wr_addr <= r_wr_addr + 1'b1;
                if (r_wr_addr == LAST) begin
                    r_rd_more <= 1'b1;
                end
            end
            if (w_issue) begin
                r_rd_addr              <= r_rd_addr + 1'b1;
                r_skid_last[r_skid_wp] <= (r_rd_addr == LAST);
                r_skid_wp              <= ~r_skid_wp;
                if ((r_rd_addr == LAST) && (LOOP == 0)) begin
                    r_rd_more <= 1'b0;
                end
            end
            if (w_pop) begin
                r_skid_rp <= ~r_skid_rp;
            end
            r_skid_cnt <= r_skid_cnt + {1'b0, w_issue} - {1'b0, w_pop};
            if (w_last_pop) begin
                r_pass_count <= r_pass_count + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = w_out_valid;
    assign o_out_data   = r_skid_data[r_skid_rp];
    assign o_state      = r_state;
    assign o_done       = (r_state == ST_DONE);
    assign o_pass_count = r_pass_count;

endmodule

// File: tb/tb_mem_fill_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_drain_ctrl
//
// Three instances: b_ (ADDR=10, LOOP=1, default widths), s_ (ADDR=4, LOOP=1,
// 16-bit data) and o_ (ADDR=3, LOOP=0, 8-bit data). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_fill_drain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- big instance ----------------
    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_restart, b_done;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_state;
    logic [15:0] b_pass;

    mem_fill_drain_ctrl u_big (
        .i_clk(clk), .i_rst(b_rst), .i_in_valid(b_in_valid), .i_in_data(b_in_data),
        .o_in_ready(b_in_ready), .o_out_valid(b_out_valid), .o_out_data(b_out_data),
        .i_out_ready(b_out_ready), .i_restart(b_restart), .o_state(b_state),
        .o_done(b_done), .o_pass_count(b_pass)
    );

    // ---------------- small instance ----------------
    logic        s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_restart, s_done;
    logic [15:0] s_in_data, s_out_data;
    logic [1:0]  s_state;
    logic [15:0] s_pass;

    mem_fill_drain_ctrl #(.WIDTH(16), .ADDR(4), .LOOP(1), .PASS_W(16)) u_small (
        .i_clk(clk), .i_rst(s_rst), .i_in_valid(s_in_valid), .i_in_data(s_in_data),
        .o_in_ready(s_in_ready), .o_out_valid(s_out_valid), .o_out_data(s_out_data),
        .i_out_ready(s_out_ready), .i_restart(s_restart), .o_state(s_state),
        .o_done(s_done), .o_pass_count(s_pass)
    );

    // ---------------- one-shot instance ----------------
    logic        o_rst, o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_restart, o_done;
    logic [7:0]  o_in_data, o_out_data;
    logic [1:0]  o_state;
    logic [3:0]  o_pass;

    mem_fill_drain_ctrl #(.WIDTH(8), .ADDR(3), .LOOP(0), .PASS_W(4)) u_once (
        .i_clk(clk), .i_rst(o_rst), .i_in_valid(o_in_valid), .i_in_data(o_in_data),
        .o_in_ready(o_in_ready), .o_out_valid(o_out_valid), .o_out_data(o_out_data),
        .i_out_ready(o_out_ready), .i_restart(o_restart), .o_state(o_state),
        .o_done(o_done), .o_pass_count(o_pass)
    );

    // Scoreboard for the randomised small-instance run.
    logic [15:0] exp_q[$];

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_fill(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = base + 16'(i);
            step();
        end
        s_in_valid = 1'b0;
    endtask

    // Drains n words with out_ready high; expected word k is base + (k mod 16).
    task automatic s_drain(input string tag, input logic [15:0] base, input int n);
        int pops = 0;
        int bad  = 0;
        int cyc  = 0;
        s_out_ready = 1'b1;
        while (pops < n && cyc < 200) begin
            if (s_out_valid) begin
                if (s_out_data !== base + 16'(pops % 16)) bad++;
                pops++;
            end
            step();
            cyc++;
        end
        s_out_ready = 1'b0;
        check_vec({tag, "_data"}, bad, 0);
        check_vec({tag, "_pops"}, pops, n);
    endtask

    task automatic s_check_reset(input string tag);
        check_vec({tag, "_state"},    s_state, 2'b00);
        check_vec({tag, "_in_ready"}, s_in_ready, 1'b1);
        check_vec({tag, "_out_valid"}, s_out_valid, 1'b0);
        check_vec({tag, "_out_data"}, s_out_data, 16'h0);
        check_vec({tag, "_done"},     s_done, 1'b0);
        check_vec({tag, "_pass"},     s_pass, 16'd0);
    endtask

    initial begin
        int bad, pops, cyc, acc, unstable;
        logic        r, prev_hold;
        logic [15:0] prev_data, e;

        // ---------------- clock/reset ----------------
        b_rst = 1; s_rst = 1; o_rst = 1;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_restart = 0;
        s_in_valid = 0; s_in_data = 0; s_out_ready = 0; s_restart = 0;
        o_in_valid = 0; o_in_data = 0; o_out_ready = 0; o_restart = 0;
        repeat (3) step();
        b_rst = 0; s_rst = 0; o_rst = 0;
        step();

        check_vec("b_rst_state",    b_state, 2'b00);
        check_vec("b_rst_in_ready", b_in_ready, 1'b1);
        check_vec("b_rst_out_valid", b_out_valid, 1'b0);
        check_vec("b_rst_out_data", b_out_data, 32'h0);
        check_vec("b_rst_pass",     b_pass, 16'd0);
        check_vec("b_rst_done",     b_done, 1'b0);

        // ---------------- big: full fill, two looped passes ----------------
        for (int i = 0; i < 1024; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 32'(i);
            step();
        end
        b_in_valid = 1'b0;
        check_vec("b_drain_entry_state", b_state, 2'b01);
        check_vec("b_drain_entry_valid", b_out_valid, 1'b0);
        check_vec("b_drain_entry_in_ready", b_in_ready, 1'b0);
        b_out_ready = 1'b1;
        step();
        check_vec("b_first_valid", b_out_valid, 1'b1);
        check_vec("b_first_data",  b_out_data, 32'h0);
        bad = 0;
        for (int n = 0; n < 2048; n++) begin
            if (n == 1024) check_vec("b_pass_after_1024", b_pass, 16'd1);
            if (!b_out_valid || b_out_data !== 32'(n % 1024)) bad++;
            step();
        end
        b_out_ready = 1'b0;
        check_vec("b_stream_errors", bad, 0);
        check_vec("b_pass_after_2048", b_pass, 16'd2);

        // ---------------- small: random fill gaps, random backpressure ----------------
        s_check_reset("s_rst");
        acc = 0; cyc = 0;
        while (acc < 16 && cyc < 200) begin
            r = 1'($urandom_range(0, 1));
            s_in_valid = r;
            s_in_data  = 16'h0100 + 16'(acc);
            if (r) exp_q.push_back(16'h0100 + 16'(acc));
            step();
            if (r) acc++;
            cyc++;
        end
        s_in_valid = 1'b0;
        check_vec("s_rand_fill_count", acc, 16);
        check_vec("s_rand_fill_state", s_state, 2'b01);

        pops = 0; cyc = 0; bad = 0; unstable = 0; prev_hold = 0; prev_data = 0;
        while (pops < 40 && cyc < 800) begin
            r = 1'($urandom_range(0, 1));
            s_out_ready = r;
            if (prev_hold && (!s_out_valid || s_out_data !== prev_data)) unstable++;
            if (s_out_valid && r) begin
                e = exp_q.pop_front();
                if (s_out_data !== e) bad++;
                exp_q.push_back(e);
                pops++;
            end
            prev_hold = s_out_valid && !r;
            prev_data = s_out_data;
            step();
            cyc++;
        end
        s_out_ready = 1'b0;
        check_vec("s_rand_order_errors", bad, 0);
        check_vec("s_rand_hold_errors", unstable, 0);
        check_vec("s_rand_pops", pops, 40);
        check_vec("s_rand_pass", s_pass, 16'd2);

        // ---------------- small: restart with two words buffered ----------------
        step();
        step();
        check_vec("s_buffered_valid", s_out_valid, 1'b1);
        s_restart = 1'b1;
        step();
        s_restart = 1'b0;
        check_vec("s_restart_out_valid", s_out_valid, 1'b0);
        check_vec("s_restart_in_ready",  s_in_ready, 1'b1);
        check_vec("s_restart_state",     s_state, 2'b00);
        check_vec("s_restart_pass",      s_pass, 16'd2);
        exp_q.delete();
        s_fill(16'h0200, 16);
        s_drain("s_refill", 16'h0200, 16);
        check_vec("s_refill_pass", s_pass, 16'd3);

        // ---------------- small: reset mid-FILL at wr_addr=5 ----------------
        s_restart = 1'b1;
        step();
        s_restart = 1'b0;
        s_fill(16'h0AA0, 5);
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        s_check_reset("s_rst_fill");
        s_fill(16'h0300, 16);
        check_vec("s_post_rst_state", s_state, 2'b01);
        s_drain("s_post_rst", 16'h0300, 16);
        check_vec("s_post_rst_pass", s_pass, 16'd1);

        // ---------------- small: reset mid-DRAIN ----------------
        step();
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        s_check_reset("s_rst_drain");

        // ---------------- small: restart coincident with a FILL accept ----------------
        s_fill(16'h0400, 3);
        s_in_valid = 1'b1;
        s_in_data  = 16'hDEAD;
        s_restart  = 1'b1;
        step();
        s_restart  = 1'b0;
        s_in_valid = 1'b0;
        check_vec("s_coinc_state", s_state, 2'b00);
        s_fill(16'h0500, 15);
        check_vec("s_coinc_15_state", s_state, 2'b00);
        s_fill(16'h050F, 1);
        check_vec("s_coinc_16_state", s_state, 2'b01);
        s_drain("s_coinc", 16'h0500, 16);

        // ---------------- one-shot: fill 8, drain once, DONE ----------------
        for (int i = 0; i < 8; i++) begin
            o_in_valid = 1'b1;
            o_in_data  = 8'h10 + 8'(i);
            step();
        end
        o_in_valid  = 1'b0;
        o_out_ready = 1'b1;
        pops = 0; cyc = 0; bad = 0;
        while (pops < 8 && cyc < 40) begin
            if (o_out_valid) begin
                if (o_out_data !== 8'h10 + 8'(pops)) bad++;
                pops++;
            end
            step();
            cyc++;
        end
        check_vec("o_data_errors", bad, 0);
        check_vec("o_pops", pops, 8);
        check_vec("o_done",      o_done, 1'b1);
        check_vec("o_state",     o_state, 2'b10);
        check_vec("o_out_valid", o_out_valid, 1'b0);
        check_vec("o_in_ready",  o_in_ready, 1'b0);
        check_vec("o_pass",      o_pass, 4'd1);
        o_in_valid = 1'b1;
        repeat (4) step();
        o_in_valid = 1'b0;
        check_vec("o_hold_state",     o_state, 2'b10);
        check_vec("o_hold_out_valid", o_out_valid, 1'b0);
        check_vec("o_hold_in_ready",  o_in_ready, 1'b0);
        o_restart = 1'b1;
        step();
        o_restart = 1'b0;
        check_vec("o_restart_state",    o_state, 2'b00);
        check_vec("o_restart_in_ready", o_in_ready, 1'b1);
        check_vec("o_restart_done",     o_done, 1'b0);
        check_vec("o_restart_pass",     o_pass, 4'd1);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
